ra_bist_march: RTL and testbench

Parametrised March C- built-in self-test controller for the toy SRAM register array. It sits between the array's functional ports and the SRAM macro, and passes functional traffic through when idle. When started, it takes over all ports, runs six march elements over every address, compares both read ports against the expected background, and reports pass/fail plus first-failure diagnostics.

---
 rtl/ra_bist_march_if.sv | 30 +++
 rtl/ra_bist_march.sv | 162 ++++++++++++++++
 tb/tb_ra_bist_march.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ra_bist_march_if.sv
// Port bundle between the array's functional side, the BIST controller and the SRAM macro.
// Signal names keep the original flat port names so existing hookups map one-to-one.
interface ra_bist_march_if #(
    parameter int ADR_W = 6,
    parameter int DAT_W = 72
);
    logic             rd0_enb_in, rd1_enb_in, wr0_enb_in;
    logic [ADR_W-1:0] rd0_adr_in, rd1_adr_in, wr0_adr_in;
    logic [DAT_W-1:0] wr0_dat_in;
    logic             rd0_enb_out, rd1_enb_out, wr0_enb_out;
    logic [ADR_W-1:0] rd0_adr_out, rd1_adr_out, wr0_adr_out;
    logic [DAT_W-1:0] wr0_dat_out;
    logic [DAT_W-1:0] rd0_dat, rd1_dat;

    // master: functional requester plus macro read data; slave: the BIST controller
    modport master (
        output rd0_enb_in, rd1_enb_in, wr0_enb_in,
        output rd0_adr_in, rd1_adr_in, wr0_adr_in, wr0_dat_in,
        input  rd0_enb_out, rd1_enb_out, wr0_enb_out,
        input  rd0_adr_out, rd1_adr_out, wr0_adr_out, wr0_dat_out,
        output rd0_dat, rd1_dat
    );
    modport slave (
        input  rd0_enb_in, rd1_enb_in, wr0_enb_in,
        input  rd0_adr_in, rd1_adr_in, wr0_adr_in, wr0_dat_in,
        output rd0_enb_out, rd1_enb_out, wr0_enb_out,
        output rd0_adr_out, rd1_adr_out, wr0_adr_out, wr0_dat_out,
        input  rd0_dat, rd1_dat
    );
endinterface

// File: rtl/ra_bist_march.sv
// March C- BIST controller for the register-array SRAM macro; transparent when not running.
// Six elements over all addresses, dual read-port compare, sticky fail and first-fail capture.
module ra_bist_march #(
    parameter int ADR_W  = 6,
    parameter int DAT_W  = 72,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    ctl,
    output logic [31:0]    status,
    ra_bist_march_if.slave bus,
    output logic           bist_fail,
    output logic           bist_passed
);
    localparam int PH_W = $clog2(RD_LAT + 1);
    localparam logic [PH_W-1:0]  PH_CMP   = PH_W'(RD_LAT);
    localparam logic [ADR_W-1:0] ADR_MAX  = '1;
    localparam logic [DAT_W-1:0] CB_PAT   = {(DAT_W/2){2'b01}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       elem_q, elem_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             start_run, step_done, last_adr, down;
    logic             cb_q, fail_q, ff_port_q;
    logic [2:0]       ff_elem_q;
    logic [ADR_W-1:0] ff_adr_q;
    logic [15:0]      fail_cnt_q;
    logic [DAT_W-1:0] bg, exp_dat, wr_dat;
    logic             cmp_en, miss0, miss1, busy, done;
    logic [16:0]      cnt_sum;
    logic [7:0]       ff_adr_ext;
    logic             unused_ctl;

    assign unused_ctl = ^ctl[31:3];

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign down = (elem_q >= 3'd3);

    // Background alternates per address parity in checkerboard mode
    assign bg      = cb_q ? (CB_PAT ^ {DAT_W{adr_q[0]}}) : '0;
    assign exp_dat = bg ^ {DAT_W{(elem_q == 3'd2) || (elem_q == 3'd4)}};
    assign wr_dat  = bg ^ {DAT_W{(elem_q == 3'd1) || (elem_q == 3'd3)}};

    assign cmp_en  = busy && (elem_q != 3'd0) && (ph_q == PH_CMP);
    assign miss0   = cmp_en && (bus.rd0_dat != exp_dat);
    assign miss1   = cmp_en && (bus.rd1_dat != exp_dat);
    assign cnt_sum = {1'b0, fail_cnt_q} + 17'(miss0) + 17'(miss1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            elem_q     <= '0;
            adr_q      <= '0;
            ph_q       <= '0;
            cb_q       <= 1'b0;
            fail_q     <= 1'b0;
            fail_cnt_q <= '0;
            ff_elem_q  <= '0;
            ff_port_q  <= 1'b0;
            ff_adr_q   <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            adr_q   <= adr_d;
            ph_q    <= ph_d;
            if (start_run) begin
                cb_q       <= ctl[2];
                fail_q     <= 1'b0;
                fail_cnt_q <= '0;
                ff_elem_q  <= '0;
                ff_port_q  <= 1'b0;
                ff_adr_q   <= '0;
            end else if (miss0 || miss1) begin
                fail_q     <= 1'b1;
                fail_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
                if (!fail_q) begin
                    ff_elem_q <= elem_q;
                    ff_port_q <= !miss0;
                    ff_adr_q  <= adr_q;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        adr_d     = adr_q;
        ph_d      = ph_q;
        start_run = 1'b0;
        step_done = (elem_q == 3'd0) || (ph_q == PH_CMP);
        last_adr  = down ? (adr_q == '0) : (adr_q == ADR_MAX);
        case (state_q)
            IDLE, DONE: begin
                if (ctl[0]) begin
                    state_d   = RUN;
                    elem_d    = '0;
                    adr_d     = '0;
                    ph_d      = '0;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (ctl[1]) begin
                    state_d = IDLE;
                end else if (!step_done) begin
                    ph_d = ph_q + PH_W'(1);
                end else begin
                    ph_d = '0;
                    // Address only wraps at element boundaries; descending elements start at the top
                    if (!last_adr) begin
                        adr_d = down ? adr_q - ADR_W'(1) : adr_q + ADR_W'(1);
                    end else if (elem_q == 3'd5) begin
                        state_d = DONE;
                    end else begin
                        elem_d = elem_q + 3'd1;
                        adr_d  = (elem_q >= 3'd2) ? ADR_MAX : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ff_adr_ext              = '0;
        ff_adr_ext[ADR_W-1:0]   = ff_adr_q;
        status      = {fail_cnt_q, ff_adr_ext, 1'b0, ff_port_q, ff_elem_q, fail_q, done, busy};
        bist_fail   = fail_q;
        bist_passed = done & ~fail_q;
        if (busy) begin
            bus.rd0_enb_out = 1'b0;
            bus.rd1_enb_out = 1'b0;
            bus.wr0_enb_out = 1'b0;
            bus.rd0_adr_out = adr_q;
            bus.rd1_adr_out = adr_q;
            bus.wr0_adr_out = adr_q;
            bus.wr0_dat_out = wr_dat;
            if (elem_q == 3'd0) begin
                bus.wr0_enb_out = 1'b1;
            end else if (ph_q == '0) begin
                bus.rd0_enb_out = 1'b1;
                bus.rd1_enb_out = 1'b1;
            end else if (ph_q == PH_CMP && elem_q != 3'd5) begin
                bus.wr0_enb_out = 1'b1;
            end
        end else begin
            bus.rd0_enb_out = bus.rd0_enb_in;
            bus.rd1_enb_out = bus.rd1_enb_in;
            bus.wr0_enb_out = bus.wr0_enb_in;
            bus.rd0_adr_out = bus.rd0_adr_in;
            bus.rd1_adr_out = bus.rd1_adr_in;
            bus.wr0_adr_out = bus.wr0_adr_in;
            bus.wr0_dat_out = bus.wr0_dat_in;
        end
    end
endmodule

// File: tb/tb_ra_bist_march.sv
// Bench for ra_bist_march: behavioural SRAM with planted faults, abstract March C- model feeding
// an op scoreboard, plus a small RD_LAT=3 instance for latency and run-length checks.
module tb_ra_bist_march;
    localparam int AW = 6, DW = 72, D = 64;
    localparam int AW2 = 4, DW2 = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ctl = '0, ctl2 = '0;
    logic [31:0] status, status2;
    logic        bist_fail, bist_passed, bf2, bp2;

    always #5 clk = ~clk;

    ra_bist_march_if #(.ADR_W(AW), .DAT_W(DW)) bus ();
    ra_bist_march_if #(.ADR_W(AW2), .DAT_W(DW2)) bus2 ();

    ra_bist_march #(.ADR_W(AW), .DAT_W(DW), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .ctl(ctl), .status(status), .bus(bus),
        .bist_fail(bist_fail), .bist_passed(bist_passed));

    ra_bist_march #(.ADR_W(AW2), .DAT_W(DW2), .RD_LAT(3)) dut2 (
        .clk(clk), .reset(reset), .ctl(ctl2), .status(status2), .bus(bus2),
        .bist_fail(bf2), .bist_passed(bp2));

    // Macro model: stuck-at bits applied on write, port-1-only flips applied on read
    logic [DW-1:0] mem [D];
    logic [DW-1:0] sa1 [D], sa0 [D], fl1 [D];
    logic [DW-1:0] rq0, rq1;
    always @(posedge clk) begin
        if (bus.wr0_enb_out)
            mem[bus.wr0_adr_out] <= (bus.wr0_dat_out | sa1[bus.wr0_adr_out]) & ~sa0[bus.wr0_adr_out];
        if (bus.rd0_enb_out) rq0 <= mem[bus.rd0_adr_out];
        if (bus.rd1_enb_out) rq1 <= mem[bus.rd1_adr_out] ^ fl1[bus.rd1_adr_out];
    end
    assign bus.rd0_dat = rq0;
    assign bus.rd1_dat = rq1;

    logic [DW2-1:0] mem2 [16];
    logic [DW2-1:0] p0 [3], p1 [3];
    always @(posedge clk) begin
        if (bus2.wr0_enb_out) mem2[bus2.wr0_adr_out] <= bus2.wr0_dat_out;
        p0[0] <= mem2[bus2.rd0_adr_out];
        p1[0] <= mem2[bus2.rd1_adr_out];
        for (int i = 1; i < 3; i++) begin
            p0[i] <= p0[i-1];
            p1[i] <= p1[i-1];
        end
    end
    assign bus2.rd0_dat = p0[2];
    assign bus2.rd1_dat = p1[2];

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        int            t;
    } op_t;

    op_t         exq[$];
    int          n_cmp = 0, n_err = 0;
    bit          mon_en = 1'b0;
    int          rel = 0;
    int          exp_len;
    logic [31:0] exp_status;

    task automatic check(string name, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] bgv(int a, bit cb, bit one);
        logic [DW-1:0] v;
        v = cb ? ({(DW/2){2'b01}} ^ {DW{a[0]}}) : '0;
        return one ? ~v : v;
    endfunction

    function automatic logic [DW-1:0] stored(int a, logic [DW-1:0] v);
        return (v | sa1[a]) & ~sa0[a];
    endfunction

    // Abstract March C- run: expected macro op stream with cycle offsets, and final status
    task automatic build_expect(bit cb);
        logic [DW-1:0] rm [D];
        int tc, cnt, fe, fp, fa;
        bit f;
        tc = 0; cnt = 0; fe = 0; fp = 0; fa = 0; f = 1'b0;
        exq.delete();
        for (int a = 0; a < D; a++) begin
            exq.push_back('{is_wr: 1'b1, adr: AW'(a), dat: bgv(a, cb, 1'b0), t: tc});
            rm[a] = stored(a, bgv(a, cb, 1'b0));
            tc++;
        end
        for (int e = 1; e <= 5; e++) begin
            for (int i = 0; i < D; i++) begin
                int a;
                logic [DW-1:0] x;
                bit m0, m1;
                a = (e >= 3) ? D - 1 - i : i;
                exq.push_back('{is_wr: 1'b0, adr: AW'(a), dat: '0, t: tc});
                x  = bgv(a, cb, (e == 2 || e == 4));
                m0 = (rm[a] != x);
                m1 = ((rm[a] ^ fl1[a]) != x);
                if ((m0 || m1) && !f) begin
                    f = 1'b1; fe = e; fp = m0 ? 0 : 1; fa = a;
                end
                cnt = cnt + int'(m0) + int'(m1);
                if (cnt > 65535) cnt = 65535;
                if (e < 5) begin
                    exq.push_back('{is_wr: 1'b1, adr: AW'(a), dat: bgv(a, cb, (e == 1 || e == 3)), t: tc + 1});
                    rm[a] = stored(a, bgv(a, cb, (e == 1 || e == 3)));
                end
                tc += 2;
            end
        end
        exp_len    = tc;
        exp_status = {cnt[15:0], 8'(fa), 1'b0, fp[0], fe[2:0], f, 1'b1, 1'b0};
    endtask

    // Monitor: every macro enable during a BIST run must match the next scoreboard entry
    always @(negedge clk) begin : mon
        op_t e;
        bit  ok;
        if (mon_en && (bus.rd0_enb_out || bus.rd1_enb_out || bus.wr0_enb_out)) begin
            n_cmp++;
            if (exq.size() == 0) begin
                n_err++;
                $display("FAIL op_unexpected t=%0d got rd=%b%b wr=%b adr=%h/%h expected none",
                         rel, bus.rd0_enb_out, bus.rd1_enb_out, bus.wr0_enb_out, bus.rd0_adr_out, bus.wr0_adr_out);
            end else begin
                e = exq.pop_front();
                if (e.is_wr)
                    ok = bus.wr0_enb_out && !bus.rd0_enb_out && !bus.rd1_enb_out &&
                         bus.wr0_adr_out == e.adr && bus.wr0_dat_out == e.dat && rel == e.t;
                else
                    ok = bus.rd0_enb_out && bus.rd1_enb_out && !bus.wr0_enb_out &&
                         bus.rd0_adr_out == e.adr && bus.rd1_adr_out == e.adr && rel == e.t;
                if (!ok) begin
                    n_err++;
                    $display("FAIL macro_op got t=%0d rd=%b%b wr=%b radr=%h/%h wadr=%h wdat=%h exp %s adr=%h dat=%h t=%0d",
                             rel, bus.rd0_enb_out, bus.rd1_enb_out, bus.wr0_enb_out, bus.rd0_adr_out,
                             bus.rd1_adr_out, bus.wr0_adr_out, bus.wr0_dat_out, e.is_wr ? "wr" : "rd",
                             e.adr, e.dat, e.t);
                end
            end
        end
        if (status[0]) rel++;
        else rel = 0;
    end

    task automatic clear_faults();
        for (int a = 0; a < D; a++) begin
            sa1[a] = '0; sa0[a] = '0; fl1[a] = '0;
        end
    endtask

    task automatic func_idle();
        bus.rd0_enb_in = 1'b0; bus.rd1_enb_in = 1'b0; bus.wr0_enb_in = 1'b0;
        bus.rd0_adr_in = '0;   bus.rd1_adr_in = '0;   bus.wr0_adr_in = '0;
        bus.wr0_dat_in = '0;
    endtask

    task automatic passthru(int n, string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rd0_enb_in = 1'($urandom); bus.rd1_enb_in = 1'($urandom); bus.wr0_enb_in = 1'($urandom);
            bus.rd0_adr_in = AW'($urandom); bus.rd1_adr_in = AW'($urandom); bus.wr0_adr_in = AW'($urandom);
            bus.wr0_dat_in = DW'({$urandom, $urandom, $urandom});
            #1;
            check(name, {bus.rd0_enb_out, bus.rd1_enb_out, bus.wr0_enb_out, bus.rd0_adr_out,
                         bus.rd1_adr_out, bus.wr0_adr_out, bus.wr0_dat_out},
                        {bus.rd0_enb_in, bus.rd1_enb_in, bus.wr0_enb_in, bus.rd0_adr_in,
                         bus.rd1_adr_in, bus.wr0_adr_in, bus.wr0_dat_in});
        end
        func_idle();
    endtask

    task automatic start_main(bit cb);
        @(negedge clk); ctl = {29'b0, cb, 2'b01};
        @(negedge clk); ctl = '0;
    endtask

    task automatic run_bist(bit cb, string name);
        int k;
        build_expect(cb);
        mon_en = 1'b1;
        start_main(cb);
        check({name, "_busy"}, status[0], 1'b1);
        k = 0;
        while (!status[1] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_len"}, k, exp_len);
        check({name, "_status"}, status, exp_status);
        check({name, "_flags"}, {bist_fail, bist_passed}, {exp_status[2], ~exp_status[2]});
        check({name, "_ops_left"}, exq.size(), 0);
        mon_en = 1'b0;
    endtask

    task automatic run_small();
        int k, nr, nw;
        k = 0; nr = 0; nw = 0;
        @(negedge clk); ctl2 = 32'h1;
        @(negedge clk); ctl2 = '0;
        while (!status2[1] && k < 1000) begin
            if (bus2.rd0_enb_out && bus2.rd1_enb_out) nr++;
            if (bus2.wr0_enb_out) nw++;
            @(negedge clk);
            k++;
        end
        check("lat3_len", k, 336);
        check("lat3_reads", nr, 80);
        check("lat3_writes", nw, 80);
        check("lat3_status", status2, 32'h0000_0002);
        check("lat3_flags", {bf2, bp2}, 2'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        logic [DW-1:0] d;
        clear_faults();
        func_idle();
        bus2.rd0_enb_in = 1'b0; bus2.rd1_enb_in = 1'b0; bus2.wr0_enb_in = 1'b0;
        bus2.rd0_adr_in = '0;   bus2.rd1_adr_in = '0;   bus2.wr0_adr_in = '0;
        bus2.wr0_dat_in = '0;
        repeat (3) @(negedge clk);
        check("reset_status", status, 32'h0);
        check("reset_flags", {bist_fail, bist_passed}, 2'b00);
        reset = 1'b0;

        run_small();
        passthru(10, "idle_passthru");

        run_bist(1'b0, "clean");
        check("clean_status_const", status, 32'h0000_0002);

        sa1[6'h13][5] = 1'b1;
        run_bist(1'b0, "sa1_13");
        check("sa1_13_status_const", status, 32'h0006_130E);
        clear_faults();

        run_bist(1'b1, "cb_clean");
        passthru(5, "done_passthru");

        fl1[6'h21][40] = 1'b1;
        run_bist(1'($urandom), "port1");
        clear_faults();

        for (int r = 0; r < 2; r++) begin
            int nf;
            nf = int'($urandom_range(1, 4));
            for (int j = 0; j < nf; j++) begin
                a = int'($urandom_range(0, D - 1));
                case ($urandom_range(0, 2))
                    0: sa1[a][$urandom_range(0, DW - 1)] = 1'b1;
                    1: sa0[a][$urandom_range(0, DW - 1)] = 1'b1;
                    default: fl1[a][$urandom_range(0, DW - 1)] = 1'b1;
                endcase
            end
            run_bist(1'($urandom), "rand");
            clear_faults();
        end

        // Abort after M1 has already recorded a failure at address 2
        sa1[2][0] = 1'b1;
        build_expect(1'b0);
        mon_en = 1'b1;
        start_main(1'b0);
        repeat (100) @(negedge clk);
        ctl = 32'h2;
        @(negedge clk);
        ctl = '0;
        mon_en = 1'b0;
        exq.delete();
        check("abort_status", status, 32'h0002_020C);
        check("abort_flags", {bist_fail, bist_passed}, 2'b10);
        a = int'($urandom_range(0, D - 1));
        d = DW'({$urandom, $urandom, $urandom});
        bus.wr0_enb_in = 1'b1; bus.wr0_adr_in = AW'(a); bus.wr0_dat_in = d;
        #1;
        check("abort_wr_pass", {bus.wr0_enb_out, bus.wr0_adr_out, bus.wr0_dat_out}, {1'b1, AW'(a), d});
        @(posedge clk); #1;
        check("abort_wr_mem", mem[a], stored(a, d));
        func_idle();
        clear_faults();

        // Reset in the middle of M3
        build_expect(1'b0);
        mon_en = 1'b1;
        start_main(1'b0);
        repeat (400) @(negedge clk);
        mon_en = 1'b0;
        exq.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_status", status, 32'h0);
        check("midrst_flags", {bist_fail, bist_passed}, 2'b00);
        passthru(3, "midrst_passthru");
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("postrst_quiet", {bus.rd0_enb_out, bus.rd1_enb_out, bus.wr0_enb_out, status}, 35'h0);
        end

        passthru(10, "final_passthru");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
